result_streamer: RTL and testbench

RESULT_STREAMER -- requirements
Module: result_streamer

---
 rtl/result_streamer.sv | 174 +++++++++++++++++
 tb/tb_result_streamer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/result_streamer.sv
// rtl/result_streamer.sv - unloads the subdivision result RAM onto a valid/ready stream
//
// Reads result RAM words 0..N-1 in ascending order, where N is word_count
// clamped to 2**ADDR_WIDTH, and emits each word once on the m_* stream.
// A two-entry FIFO absorbs the one-cycle RAM read latency and consumer stalls.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           single-cycle unload request (ignored unless idle)
//   word_count      requested word count, sampled on an accepted start
//   en, a, we, di   result RAM port (read-only use: we and di tied to zero)
//   do_data         result RAM read data, valid the cycle after en
//   m_valid, m_ready, m_data, m_last   output word stream
//   busy            high from the cycle after an accepted start until done
//   done            one-cycle completion pulse
module result_streamer #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           word_count,
  output logic                  en,
  output logic [ADDR_WIDTH-1:0] a,
  output logic [3:0]            we,
  output logic [DATA_WIDTH-1:0] di,
  input  logic [DATA_WIDTH-1:0] do_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  // One extra bit so that a full 2**ADDR_WIDTH unload can be represented
  // and terminated without the counter wrapping.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] MAX_WORDS = CW'(1) << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         n_words;
  logic [CW-1:0]         addr;
  logic                  pend;       // read issued last cycle, data on do_data now
  logic                  pend_last;  // that read was for word N-1
  logic [1:0]            cnt;        // FIFO occupancy
  logic [DATA_WIDTH-1:0] d0, d1;     // d0 is the head
  logic                  l0, l1;
  logic                  pop;
  logic                  push;
  logic [2:0]            level;
  logic                  rd_ok;
  logic                  last_rd;

  assign m_valid = (cnt != 2'd0);
  assign m_data  = d0;
  assign m_last  = l0 & m_valid;
  assign we      = 4'b0000;
  assign di      = '0;
  assign a       = addr[ADDR_WIDTH-1:0];

  assign pop  = m_valid & m_ready;
  assign push = pend;

  // A new read lands in the FIFO one cycle after it is issued, so it may only
  // go out if everything already committed to the FIFO, minus the word leaving
  // this cycle, leaves room for it. Issuing in the same cycle as the decision
  // keeps the loop short enough for one word per cycle with only two entries.
  assign level   = {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
  assign rd_ok   = (level < 3'd2);
  assign en      = (state == RUN) && rd_ok;
  assign last_rd = (addr == n_words - CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      n_words   <= '0;
      addr      <= '0;
      pend      <= 1'b0;
      pend_last <= 1'b0;
      cnt       <= 2'd0;
      d0        <= '0;
      d1        <= '0;
      l0        <= 1'b0;
      l1        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pend      <= en;
      pend_last <= en & last_rd;

      // Shift-register FIFO: the head only moves on a pop or when the FIFO
      // is empty, so m_data/m_last hold through consumer stalls.
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            d0 <= do_data;
            l0 <= pend_last;
          end else begin
            d1 <= do_data;
            l1 <= pend_last;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          d0  <= d1;
          l0  <= l1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            d0 <= do_data;
            l0 <= pend_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= do_data;
            l1 <= pend_last;
          end
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            addr <= '0;
            busy <= 1'b1;
            if (word_count == 32'd0) begin
              done  <= 1'b0;
              state <= DONE;
            end else begin
              if (word_count > {{(32-CW){1'b0}}, MAX_WORDS})
                n_words <= MAX_WORDS;
              else
                n_words <= word_count[CW-1:0];
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (en) begin
            // The address stays on the last word so it never wraps to 0.
            if (last_rd) state <= DRAIN;
            else         addr  <= addr + CW'(1);
          end
        end
        DRAIN: begin
          if (pop && l0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          // Arriving from DRAIN the pulse is already up; the empty-unload
          // path arrives with it low and raises it here, one cycle later.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_streamer.sv
// tb/tb_result_streamer.sv - self-checking bench for result_streamer
module tb_result_streamer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] word_count;
  logic        en;
  logic [10:0] a;
  logic [3:0]  we;
  logic [31:0] di;
  logic [31:0] do_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [31:0] ram [0:2047];

  result_streamer #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .en(en), .a(a), .we(we), .di(di), .do_data(do_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read result RAM.
  always @(posedge clk) begin
    if (en) do_data <= ram[a];
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Runs one unload starting in cycle 0 and compares it against the expected
  // stream: words ram[0..n-1] in order, last flag on the final word only,
  // reads at ascending addresses, at most two reads not yet consumed,
  // busy/done behaviour, and optional first-valid / done cycle numbers.
  task automatic run_unload(input int wc, input int n, input int mode, input int restart_at,
                            input int exp_first, input int exp_done, input string tag);
    int rd, pops, first, done_cyc, ndone, max_out, cyc;
    logic        stalled;
    logic [31:0] held_d;
    logic        held_l;
    bit          fin;
    rd = 0; pops = 0; first = -1; done_cyc = -1; ndone = 0; max_out = 0;
    stalled = 1'b0; held_d = '0; held_l = 1'b0; fin = 1'b0; cyc = 0;
    start = 1'b1;
    word_count = wc;
    while (!fin) begin
      if (mode == 0)      m_ready = 1'b1;
      else if (mode == 1) m_ready = (cyc % 3 == 0);
      else                m_ready = ($urandom_range(0, 3) != 0);
      if (cyc == restart_at) begin
        start = 1'b1;
        word_count = 32'd3;
      end
      @(negedge clk);
      chk({tag, " we_di"}, {28'd0, we, di}, 64'd0);
      if (en) begin
        chk({tag, " addr"}, 64'(a), 64'(rd));
        rd++;
      end
      if (m_valid) begin
        if (first < 0) first = cyc;
        if (stalled) begin
          chk({tag, " stall_data"}, 64'(m_data), 64'(held_d));
          chk({tag, " stall_last"}, 64'(m_last), 64'(held_l));
        end
        if (m_ready) begin
          chk({tag, " data"}, 64'(m_data), (pops < 2048) ? 64'(ram[pops]) : 64'hx);
          chk({tag, " last"}, 64'(m_last), 64'(pops == n - 1));
          pops++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d = m_data;
          held_l = m_last;
        end
      end
      if (rd - pops > max_out) max_out = rd - pops;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
        fin = 1'b1;
      end else if (cyc >= 1) begin
        chk({tag, " busy"}, 64'(busy), 64'd1);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc++;
      if (!fin && cyc > 6000) begin
        errors++;
        checks++;
        $display("FAIL %s timeout: no done after %0d cycles", tag, cyc);
        fin = 1'b1;
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    if (done) ndone++;
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    chk({tag, " valid_after"}, 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, " words"}, 64'(pops), 64'(n));
    chk({tag, " reads"}, 64'(rd), 64'(n));
    chk({tag, " done_count"}, 64'(ndone), 64'd1);
    chk({tag, " first_valid_cycle"}, 64'(first), 64'(exp_first));
    if (exp_done >= 0) chk({tag, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
    checks++;
    if (max_out > 2) begin
      errors++;
      $display("FAIL %s outstanding: got %0d expected at most 2", tag, max_out);
    end
  endtask

  typedef struct {
    int wc;
    int n;
    int mode;       // 0: ready always 1, 1: ready 1,0,0 repeating
    int restart_at; // cycle of a second start pulse, -1 for none
    int exp_first;
    int exp_done;   // -1 where stall timing makes it data dependent
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{wc: 4,    n: 4,    mode: 0, restart_at: -1, exp_first: 3,  exp_done: 7};
    vecs[1] = '{wc: 0,    n: 0,    mode: 0, restart_at: -1, exp_first: -1, exp_done: 2};
    vecs[2] = '{wc: 1,    n: 1,    mode: 0, restart_at: -1, exp_first: 3,  exp_done: 4};
    vecs[3] = '{wc: 2,    n: 2,    mode: 0, restart_at: -1, exp_first: 3,  exp_done: 5};
    vecs[4] = '{wc: 4,    n: 4,    mode: 1, restart_at: -1, exp_first: 3,  exp_done: -1};
    vecs[5] = '{wc: 5000, n: 2048, mode: 0, restart_at: -1, exp_first: 3,  exp_done: 2051};
    vecs[6] = '{wc: 2049, n: 2048, mode: 0, restart_at: -1, exp_first: 3,  exp_done: 2051};
    vecs[7] = '{wc: 6,    n: 6,    mode: 0, restart_at: 2,  exp_first: 3,  exp_done: 9};
    vecs[8] = '{wc: 9,    n: 9,    mode: 1, restart_at: 4,  exp_first: 3,  exp_done: -1};

    for (int i = 0; i < 2048; i++) ram[i] = 32'hA0 + i;

    rst_n = 1'b0;
    start = 1'b0;
    word_count = '0;
    m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", {en, a, we, m_valid, m_last, busy, done}, 64'd0);
    chk("reset data", {di, m_data}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      run_unload(vecs[i].wc, vecs[i].n, vecs[i].mode, vecs[i].restart_at,
                 vecs[i].exp_first, vecs[i].exp_done, $sformatf("vec%0d", i));
    end

    // Reset in the cycle after the second word of an 8-word unload.
    begin
      int pops;
      pops = 0;
      start = 1'b1;
      word_count = 32'd8;
      for (int c = 0; c < 6; c++) begin
        m_ready = (c != 5);
        if (c == 5) rst_n = 1'b0;
        @(negedge clk);
        if (m_valid && m_ready) pops++;
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      rst_n = 1'b1;
      chk("midreset words_before", 64'(pops), 64'd2);
      @(negedge clk);
      chk("midreset valid", 64'(m_valid), 64'd0);
      chk("midreset done", 64'(done), 64'd0);
      chk("midreset busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
      run_unload(8, 8, 0, -1, 3, 11, "after_reset");
    end

    // Randomized unloads against the bench's expected stream.
    for (int r = 0; r < 20; r++) begin
      int wc;
      int n;
      for (int i = 0; i < 16; i++) ram[i] = $urandom;
      wc = $urandom_range(0, 14);
      n = (wc > 2048) ? 2048 : wc;
      run_unload(wc, n, 2, -1, (n > 0) ? 3 : -1, (n == 0) ? 2 : -1, $sformatf("rand%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
